uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
Boot-time block upstream of the CPU core. It receives a program image over a UART RX line and writes it word-by-word into instruction memory through the MMU's load port. It holds the CPU in reset until the whole image is written, then releases it. It removes the need to resynthesise whenever the program changes.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 4
ADDR_WIDTH, 8, instruction-memory word-address width; capacity = 2^ADDR_WIDTH words

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset; one clock
uartRx  input  1  asynchronous serial line, idle high, 8N1, LSB first
memWriteEnable  output  1  one-cycle write strobe to instruction memory
memAddress  output  ADDR_WIDTH  word address of current write
memWriteData  output  32  word to write
cpuReset  output  1  held high until the image is loaded; ORed into the CPU rst
loading  output  1  high while the loader is receiving the length or data fields
done  output  1  image loaded, CPU released
error  output  1  framing error or oversize length; sticky until rst

Behaviour:
Reset values:
- memWriteEnable=0, memAddress=0, memWriteData=0, cpuReset=1, loading=1, done=0, error=0.
- Internal state: RX FSM=IDLE, loader FSM=LEN_LO, rx synchroniser=2'b11.

RX path:
- uartRx passes through a 2-flop synchroniser; all logic uses the synchronised value.
- IDLE: a low level moves the FSM to START and clears the bit counter.
- START: wait CLKS_PER_BIT/2 (integer divide) cycles, then resample. Low -> DATA. High -> false start, return to IDLE with no error.
- DATA: sample every CLKS_PER_BIT cycles, 8 samples, shifted in LSB first.
- STOP: sample after CLKS_PER_BIT cycles. High -> byteValid pulses for 1 cycle with the byte. Low -> frameError pulses; no byteValid.
- After STOP, return to IDLE the next cycle. A start bit beginning immediately after the stop sample is accepted.

Loader FSM, advanced only on byteValid:
- LEN_LO: latch count[7:0] -> LEN_HI.
- LEN_HI: latch count[15:8].
  - count==0 -> DONE.
  - count > 2^ADDR_WIDTH -> ERROR.
  - otherwise -> DATA with wordIndex=0, byteIndex=0.
- DATA: bytes are little-endian. Byte k lands in word bits [8k+7:8k]. byteIndex wraps 3->0.
  - On the 4th byte, in the same clock: memWriteData=assembled word, memAddress=wordIndex, memWriteEnable=1.
  - memWriteEnable lasts exactly 1 cycle. memAddress and memWriteData hold their values until the next write.
  - wordIndex increments after each write. When written words == count -> DONE, taken on the cycle after the final strobe.
- DONE: cpuReset=0, done=1, loading=0. Further UART bytes are ignored; no writes occur.
- ERROR: cpuReset=1, error=1, loading=0, memWriteEnable=0. Stays here until rst.
- frameError in LEN_LO, LEN_HI or DATA -> ERROR. frameError in DONE is ignored.

Boundaries:
- count == 2^ADDR_WIDTH is legal; the last address is all ones, with no wrap.
- rst mid-byte or mid-image aborts the load, returns to reset values, and discards any partial word. Already-written memory is not cleared.
- rst has priority over every other event.
- Latency: memWriteEnable asserts 1 cycle after the synchronised stop-bit sample of the 4th byte. Including the synchroniser, that is 3 cycles after the stop-bit midpoint on uartRx.

Test Plan:
1. CLKS_PER_BIT=4. Send 02 00, then 13 00 50 00, then 93 00 10 00 -> two strobes: addr 0 data 0x00500013, then addr 1 data 0x00100093. Next cycle: done=1, cpuReset=0.
2. Send 00 00 -> no memWriteEnable ever; done=1 and cpuReset=0 one cycle after the 2nd byteValid.
3. ADDR_WIDTH=8. Send 01 01 (count=257) -> error=1, cpuReset=1, no writes. Sending 00 00 afterwards changes nothing until rst.
4. Send 01 00 AA, then a byte with stop bit driven low -> error=1 and no write. Assert rst for 1 cycle, then send 01 00 EF BE AD DE -> addr 0 data 0xDEADBEEF, done=1.
5. Glitch uartRx low for CLKS_PER_BIT/2-1 cycles while IDLE -> no byte, no error. Then send 01 00 78 56 34 12 -> addr 0 data 0x12345678.
6. Assert rst midway through the 3rd data byte of a 2-word image, then send the full image from scenario 1 -> exactly two strobes with scenario-1 values, and no stale partial word.

Source files
------------

// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if: serial input plus memory-load and boot-status signals of the program loader.
interface uart_program_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic uartRx;
    logic memWriteEnable;
    logic [ADDR_WIDTH-1:0] memAddress;
    logic [31:0] memWriteData;
    logic cpuReset;
    logic loading;
    logic done;
    logic error;
    modport master (
        input uartRx,
        output memWriteEnable, memAddress, memWriteData, cpuReset, loading, done, error
    );
    modport slave (
        output uartRx,
        input memWriteEnable, memAddress, memWriteData, cpuReset, loading, done, error
    );
endinterface

// File: rtl/uart_program_loader.sv
// uart_program_loader: receives a length-prefixed little-endian image over UART 8N1, writes it into
// instruction memory word by word and holds the CPU in reset until the whole image is in place.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH = 8
) (
    input logic clk,
    input logic rst,
    uart_program_loader_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_DONE, LD_ERROR} ld_state_t;

    rx_state_t rx_state, rx_next;
    ld_state_t ld_state, ld_next;
    logic [1:0] sync;
    logic rx;
    logic [CW-1:0] cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic byte_valid, frame_error;
    logic [7:0] count_lo;
    logic [15:0] count, len;
    logic [ADDR_WIDTH:0] words;
    logic [1:0] byte_idx;
    logic [23:0] word_buf;
    logic we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0] wdata;

    assign rx = sync[1];
    assign len = {shift, count_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            ld_state <= LD_LEN_LO;
        end else begin
            rx_state <= rx_next;
            ld_state <= ld_next;
        end
    end

    // byte_valid/frame_error fire in the stop-sample cycle so the write strobe lands one clock later
    always_comb begin
        rx_next = rx_state;
        byte_valid = 1'b0;
        frame_error = 1'b0;
        case (rx_state)
            RX_IDLE: rx_next = rx ? RX_IDLE : RX_START;
            RX_START: if (cnt == HALF) rx_next = rx ? RX_IDLE : RX_DATA;
            RX_DATA: if (cnt == FULL && bit_cnt == 3'd7) rx_next = RX_STOP;
            RX_STOP: if (cnt == FULL) begin
                rx_next = RX_IDLE;
                byte_valid = rx;
                frame_error = !rx;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
            cnt <= '0;
            bit_cnt <= '0;
            shift <= '0;
        end else begin
            sync <= {sync[0], bus.uartRx};
            cnt <= (rx_state == RX_IDLE || cnt == (rx_state == RX_START ? HALF : FULL)) ? '0 : cnt + 1'b1;
            if (rx_state == RX_IDLE) bit_cnt <= '0;
            else if (rx_state == RX_DATA && cnt == FULL) begin
                bit_cnt <= bit_cnt + 1'b1;
                shift <= {rx, shift[7:1]};
            end
        end
    end

    // DONE is taken the cycle after the final strobe, once the write counter has caught up
    always_comb begin
        ld_next = ld_state;
        case (ld_state)
            LD_LEN_LO: if (byte_valid) ld_next = LD_LEN_HI;
            LD_LEN_HI: if (byte_valid) ld_next = (len == '0) ? LD_DONE : ({1'b0, len} > CAP) ? LD_ERROR : LD_DATA;
            LD_DATA: if (we && 32'(count) == 32'(words)) ld_next = LD_DONE;
            default: ld_next = ld_state;
        endcase
        if (frame_error && ld_state inside {LD_LEN_LO, LD_LEN_HI, LD_DATA}) ld_next = LD_ERROR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_lo <= '0;
            count <= '0;
            words <= '0;
            byte_idx <= '0;
            word_buf <= '0;
            we <= 1'b0;
            addr <= '0;
            wdata <= '0;
        end else begin
            we <= 1'b0;
            if (byte_valid && ld_state == LD_LEN_LO) count_lo <= shift;
            if (byte_valid && ld_state == LD_LEN_HI) begin
                count <= len;
                words <= '0;
                byte_idx <= '0;
            end
            if (byte_valid && ld_state == LD_DATA) begin
                byte_idx <= byte_idx + 1'b1;
                word_buf <= {shift, word_buf[23:8]};
                if (byte_idx == 2'd3) begin
                    we <= 1'b1;
                    addr <= words[ADDR_WIDTH-1:0];
                    wdata <= {shift, word_buf};
                    words <= words + 1'b1;
                end
            end
        end
    end

    assign bus.memWriteEnable = we;
    assign bus.memAddress = addr;
    assign bus.memWriteData = wdata;
    assign bus.cpuReset = ld_state != LD_DONE;
    assign bus.done = ld_state == LD_DONE;
    assign bus.error = ld_state == LD_ERROR;
    assign bus.loading = ld_state inside {LD_LEN_LO, LD_LEN_HI, LD_DATA};
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: drives UART frames into the loader and compares memory writes and boot
// status against a byte-stream model of the image format.
module tb_uart_program_loader;
    localparam int CPB = 4;
    localparam int AW = 8;
    typedef logic [7:0] bytes_t[$];
    typedef logic [AW+31:0] wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_we = 0;
    int done_gap = -1;
    logic prev_done = 1'b0;
    wr_t seen[$];
    wr_t expq[$];
    int exp_st;
    bytes_t s1, img;

    uart_program_loader_if #(.ADDR_WIDTH(AW)) bus ();
    uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.memWriteEnable) begin
            seen.push_back({bus.memAddress, bus.memWriteData});
            last_we = cyc;
        end
        if (bus.done && !prev_done) done_gap = cyc - last_we;
        prev_done = bus.done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.uartRx = 1'b1;
        @(negedge clk);
        check("rst we", bus.memWriteEnable, 0);
        check("rst addr", bus.memAddress, 0);
        check("rst data", bus.memWriteData, 0);
        check("rst cpuReset", bus.cpuReset, 1);
        check("rst loading", bus.loading, 1);
        check("rst done", bus.done, 0);
        check("rst error", bus.error, 0);
        rst = 1'b0;
        seen.delete();
        done_gap = -1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int cut);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < cut; i++) begin
            bus.uartRx = frame[i];
            repeat (CPB) @(negedge clk);
        end
        bus.uartRx = 1'b1;
    endtask

    // Image format: 16-bit LE word count, then count little-endian 32-bit words.
    // exp_st: 0 still loading, 1 done, 2 error.
    task automatic model(input bytes_t b);
        int n;
        n = int'(b[0]) | (int'(b[1]) << 8);
        expq.delete();
        if (n == 0) exp_st = 1;
        else if (n > (1 << AW)) exp_st = 2;
        else begin
            for (int w = 0; w < n && 2 + 4 * w + 3 < b.size(); w++)
                expq.push_back({AW'(w), b[2 + 4 * w + 3], b[2 + 4 * w + 2], b[2 + 4 * w + 1], b[2 + 4 * w]});
            exp_st = (expq.size() == n) ? 1 : 0;
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, " nwrites"}, seen.size(), expq.size());
        foreach (expq[i]) if (i < seen.size()) check($sformatf("%s wr%0d", tag, i), seen[i], expq[i]);
        check({tag, " done"}, bus.done, exp_st == 1);
        check({tag, " error"}, bus.error, exp_st == 2);
        check({tag, " cpuReset"}, bus.cpuReset, exp_st != 1);
        check({tag, " loading"}, bus.loading, exp_st == 0);
        if (exp_st == 1 && expq.size() > 0) check({tag, " done_gap"}, done_gap, 1);
    endtask

    task automatic run_image(input string tag, input bytes_t b);
        model(b);
        foreach (b[i]) begin
            send_byte(b[i], 1'b1, 10);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (4 * CPB) @(negedge clk);
        check_result(tag);
    endtask

    initial begin
        bus.uartRx = 1'b1;
        s1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        apply_reset();
        run_image("s1", s1);
        check("s1 first", seen.size() > 0 ? seen[0] : '0, {8'd0, 32'h00500013});
        check("s1 second", seen.size() > 1 ? seen[1] : '0, {8'd1, 32'h00100093});

        apply_reset();
        img = '{8'h00, 8'h00};
        run_image("s2", img);

        apply_reset();
        img = '{8'h01, 8'h01, 8'h00, 8'h00};
        run_image("s3", img);

        apply_reset();
        send_byte(8'h01, 1'b1, 10);
        send_byte(8'h00, 1'b1, 10);
        send_byte(8'hAA, 1'b1, 10);
        send_byte(8'h5A, 1'b0, 10);
        repeat (4 * CPB) @(negedge clk);
        check("s4 frame error", bus.error, 1);
        check("s4 frame cpuReset", bus.cpuReset, 1);
        check("s4 frame loading", bus.loading, 0);
        check("s4 frame nwrites", seen.size(), 0);
        apply_reset();
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_image("s4", img);
        check("s4 word", seen.size() > 0 ? seen[0] : '0, {8'd0, 32'hDEADBEEF});

        apply_reset();
        repeat (5) @(negedge clk);
        bus.uartRx = 1'b0;
        repeat (CPB / 2 - 1) @(negedge clk);
        bus.uartRx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check("s5 glitch error", bus.error, 0);
        check("s5 glitch loading", bus.loading, 1);
        check("s5 glitch nwrites", seen.size(), 0);
        img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        run_image("s5", img);
        check("s5 word", seen.size() > 0 ? seen[0] : '0, {8'd0, 32'h12345678});

        apply_reset();
        for (int i = 0; i < 4; i++) send_byte(s1[i], 1'b1, 10);
        send_byte(8'h50, 1'b1, 5);
        apply_reset();
        repeat (2 * CPB) @(negedge clk);
        run_image("s6", s1);

        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(1, 12);
            img.delete();
            img.push_back(8'(n));
            img.push_back(8'h00);
            for (int k = 0; k < 4 * n; k++) img.push_back(8'($urandom));
            apply_reset();
            run_image($sformatf("rand%0d", r), img);
        end

        img.delete();
        img.push_back(8'h00);
        img.push_back(8'h01);
        for (int k = 0; k < 4 * (1 << AW); k++) img.push_back(8'($urandom));
        apply_reset();
        run_image("cap", img);
        check("cap last addr", seen.size() == (1 << AW) ? seen[(1 << AW) - 1][AW+31:32] : '0, {AW{1'b1}});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
